// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: state encoding and header byte constants shared by the loader files
package boot_loader_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CNT_HI = 3'd1;
  localparam logic [2:0] S_CNT_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;
  localparam logic [7:0] HDR_INST = 8'h49;
  localparam logic [7:0] HDR_DATA = 8'h44;
  localparam logic [7:0] HDR_GO   = 8'h47;
  function automatic logic is_seg(input logic [7:0] b);
    return b == HDR_INST || b == HDR_DATA;
  endfunction
endpackage

// File: rtl/boot_loader_if.sv
// boot_loader_if: byte-stream input and memory write port of the boot loader
// in_valid/in_data/in_ready: upstream byte handshake
// mem_we/mem_sel/mem_addr/mem_wdata: word write port (sel 0 = imem, 1 = dmem)
interface boot_loader_if #(parameter int ADDR_W = 8);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  modport master (output in_valid, in_data, input in_ready, mem_we, mem_sel, mem_addr, mem_wdata);
  modport slave (input in_valid, in_data, output in_ready, mem_we, mem_sel, mem_addr, mem_wdata);
endinterface

// File: rtl/boot_loader_word_assembler.sv
// word_assembler: shifts in bytes MSB first and pulses word_valid after every 4th byte
// clk: clock; clr: sync clear (reset or header); en: byte accepted; din: byte
// last: next accepted byte completes a word; word_valid/word: registered result
module word_assembler (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic        last,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [1:0] cnt;
  assign last = cnt == 2'd3;
  always_ff @(posedge clk)
    if (clr) begin
      cnt <= '0;
      word <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= en && last;
      if (en) begin
        cnt <= cnt + 2'd1;
        word <= {word[23:0], din};
      end
    end
endmodule

// File: rtl/boot_loader.sv
// boot_loader: parses framed byte stream into imem/dmem word writes, holds CPU in reset until go
// clk: clock; rst: sync active-low reset; bus: byte input + memory write port
// cpu_rst: CPU reset (released only in DONE); load_done/load_err: sticky status
module boot_loader import boot_loader_pkg::*; #(
  parameter int ADDR_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  boot_loader_if.slave bus,
  output logic         cpu_rst,
  output logic         load_done,
  output logic         load_err
);
  localparam int CW = ADDR_W + 1;
  logic [2:0]        state, nxt;
  logic [7:0]        cnt_hi, csum;
  logic [CW-1:0]     left;
  logic [ADDR_W-1:0] addr;
  logic [16:0]       cnt;
  logic              sel, xfer, hdr, last;
  assign bus.in_ready = rst && state != S_DONE && state != S_ERR;
  assign xfer = bus.in_valid && bus.in_ready;
  assign hdr = xfer && state == S_IDLE;
  assign cnt = {1'b0, cnt_hi, bus.in_data};
  assign bus.mem_addr = addr;
  assign bus.mem_sel = sel;
  assign cpu_rst = state != S_DONE;
  assign load_done = state == S_DONE;
  assign load_err = state == S_ERR;
  // clearing on reset as well as header drops any partial word without a write
  word_assembler u_wa (
    .clk(clk),
    .clr(!rst || hdr),
    .en(xfer && state == S_DATA),
    .din(bus.in_data),
    .last(last),
    .word_valid(bus.mem_we),
    .word(bus.mem_wdata)
  );
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (xfer) nxt = is_seg(bus.in_data) ? S_CNT_HI : bus.in_data == HDR_GO ? S_DONE : S_ERR;
      S_CNT_HI: if (xfer) nxt = S_CNT_LO;
      S_CNT_LO: if (xfer) nxt = cnt == '0 ? S_CSUM : cnt > 17'(2 ** ADDR_W) ? S_ERR : S_DATA;
      S_DATA:   if (xfer && last && left == CW'(1)) nxt = S_CSUM;
      S_CSUM:   if (xfer) nxt = csum == bus.in_data ? S_IDLE : S_ERR;
      default:  nxt = state;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= S_IDLE;
      cnt_hi <= '0;
      left <= '0;
      addr <= '0;
      csum <= '0;
      sel <= 1'b0;
    end else begin
      state <= nxt;
      csum <= hdr ? 8'h00 : xfer && (state == S_CNT_HI || state == S_CNT_LO || state == S_DATA) ? csum ^ bus.in_data : csum;
      addr <= hdr ? '0 : bus.mem_we ? addr + ADDR_W'(1) : addr;
      if (hdr && is_seg(bus.in_data)) sel <= bus.in_data == HDR_DATA;
      if (xfer && state == S_CNT_HI) cnt_hi <= bus.in_data;
      if (xfer && state == S_CNT_LO) left <= CW'(cnt);
      else if (xfer && state == S_DATA && last) left <= left - CW'(1);
    end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed frames with a write scoreboard for boot_loader
module tb_boot_loader;
  localparam int AW = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cpu_rst, load_done, load_err;
  int errors = 0;
  int checks = 0;
  logic [AW+32:0] exp_q[$];
  logic [31:0] wq[$];
  always #5 clk = ~clk;
  boot_loader_if #(.ADDR_W(AW)) bus();
  boot_loader #(.ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .cpu_rst(cpu_rst),
    .load_done(load_done),
    .load_err(load_err)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk)
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_write", bus.mem_we, 1'b0);
      else chk("write", {bus.mem_sel, bus.mem_addr, bus.mem_wdata}, exp_q.pop_front());
    end
  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = b;
    while (bus.in_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n == 8) chk("ready_timeout", bus.in_ready, 1'b1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic offer(input logic [7:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = b;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic seg(input logic [7:0] h, input bit bad, input bit gaps);
    logic [15:0] n;
    logic [7:0] c;
    n = 16'(wq.size());
    c = n[15:8] ^ n[7:0];
    send(h);
    send(n[15:8]);
    send(n[7:0]);
    foreach (wq[i]) begin
      exp_q.push_back({h == 8'h44, AW'(i), wq[i]});
      for (int k = 3; k >= 0; k--) begin
        send(wq[i][8*k+:8]);
        c ^= wq[i][8*k+:8];
        if (gaps) @(posedge clk);
      end
    end
    send(bad ? 8'h00 : c);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cpu_rst", cpu_rst, 1'b1);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_sel", bus.mem_sel, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_load_done", load_done, 1'b0);
    chk("rst_load_err", load_err, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_rst", bus.in_ready, 1'b1);
    wq = '{32'hDEADBEEF, 32'h00000001};
    seg(8'h49, 1'b0, 1'b0);
    chk("inst_pending", exp_q.size(), 0);
    chk("inst_err", load_err, 1'b0);
    chk("inst_cpu_rst_held", cpu_rst, 1'b1);
    send(8'h47);
    chk("go_cpu_rst", cpu_rst, 1'b0);
    chk("go_done", load_done, 1'b1);
    chk("go_ready", bus.in_ready, 1'b0);
    do_reset();
    wq = '{32'h12345678};
    seg(8'h44, 1'b0, 1'b1);
    chk("data_pending", exp_q.size(), 0);
    chk("data_err", load_err, 1'b0);
    chk("data_sel", bus.mem_sel, 1'b1);
    do_reset();
    wq = '{32'hDEADBEEF, 32'h00000001};
    seg(8'h49, 1'b1, 1'b0);
    chk("badcs_pending", exp_q.size(), 0);
    chk("badcs_err", load_err, 1'b1);
    chk("badcs_ready", bus.in_ready, 1'b0);
    offer(8'h47);
    chk("badcs_go_cpu_rst", cpu_rst, 1'b1);
    chk("badcs_go_done", load_done, 1'b0);
    do_reset();
    send(8'h5A);
    chk("badhdr_err", load_err, 1'b1);
    chk("badhdr_ready", bus.in_ready, 1'b0);
    do_reset();
    send(8'h49);
    send(8'h01);
    send(8'h01);
    chk("oversize_err", load_err, 1'b1);
    repeat (3) @(posedge clk);
    do_reset();
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back((32'(i) * 32'h01030507) ^ 32'hA55A0F0F);
    seg(8'h44, 1'b0, 1'b0);
    chk("full_pending", exp_q.size(), 0);
    chk("full_err", load_err, 1'b0);
    do_reset();
    send(8'h44);
    send(8'h00);
    send(8'h01);
    send(8'h12);
    send(8'h34);
    do_reset();
    send(8'h44);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    chk("midrst_cpu_rst_held", cpu_rst, 1'b1);
    send(8'h47);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_done", load_done, 1'b1);
    chk("midrst_cpu_rst", cpu_rst, 1'b0);
    chk("midrst_err", load_err, 1'b0);
    chk("final_pending", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
